// File: rtl/logic_gate_unit.sv
// -----------------------------------------------------------------------------
// logic_gate_unit
//
// Pipelined bitwise logic unit. Each accepted beat applies one of eight gate
// functions across a WIDTH-bit vector. The result travels through a PIPE-stage
// registered pipeline and leaves with a valid/ready handshake. An accumulate
// mode folds successive A words through the selected gate using an internal
// accumulator (ACC). A wrapping counter reports how many beats were accepted.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//   PIPE   pipeline depth = input-to-output latency in cycles (1..4)
//   CNT_W  width of the accepted-beat counter
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   unit can accept a beat this cycle
//   op         gate select, sampled with the beat
//   acc_en     beat belongs to an accumulate fold
//   acc_start  first beat of a fold (only meaningful with acc_en=1)
//   A, B       operands (B unused in accumulate mode)
//   out_valid  Y holds a valid result
//   out_ready  downstream accepts Y this cycle
//   Y          result
//   beat_cnt   count of accepted input beats, wraps
// -----------------------------------------------------------------------------
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  function automatic logic [WIDTH-1:0] gate_fn(
    input op_e              sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] res;
    case (sel)
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_NAND: res = ~(x & y);
      OP_NOR:  res = ~(x | y);
      OP_XOR:  res = x ^ y;
      OP_XNOR: res = ~(x ^ y);
      OP_NOT:  res = ~x;
      default: res = x;  // OP_BUF
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PIPE-1:0][WIDTH-1:0] stg_data_q;
  logic [PIPE-1:0]            stg_vld_q;
  logic [WIDTH-1:0]           acc_q;
  logic [WIDTH-1:0]           acc_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;

  logic                       adv;
  logic                       accept;
  logic [WIDTH-1:0]           r_d;

  // The whole pipeline moves as one unit: it advances whenever the output
  // stage is empty or being drained. Bubbles are deliberately not squeezed
  // out during a stall so that every stage keeps a fixed position.
  assign out_valid = stg_vld_q[PIPE-1];
  assign Y         = stg_data_q[PIPE-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign accept    = in_valid & in_ready;
  assign beat_cnt  = cnt_q;

  // Result computed at acceptance, plus the accumulator's next value.
  always_comb begin
    r_d   = gate_fn(op_e'(op), A, B);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (acc_en) begin
      if (acc_start) begin
        r_d = A;
      end else begin
        r_d = gate_fn(op_e'(op), acc_q, A);
      end
    end
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (acc_en) begin
        acc_d = r_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Pipeline stages. Stage 0 captures a new result or a bubble; later stages
  // copy their predecessor. Bubble data is left as-is since it is never
  // observed with out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data_q <= '0;
      stg_vld_q  <= '0;
    end else if (adv) begin
      stg_vld_q[0] <= accept;
      if (accept) begin
        stg_data_q[0] <= r_d;
      end
      for (int i = 1; i < PIPE; i++) begin
        stg_vld_q[i]  <= stg_vld_q[i-1];
        stg_data_q[i] <= stg_data_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

  // Main instance: 8-bit, 2-stage, 4-bit counter (to reach the wrap quickly).
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, acc_en, acc_start, out_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       in_ready, out_valid;
  logic [7:0] y;
  logic [3:0] beat_cnt;

  // Second instance: 1-bit, 3-stage, 16-bit counter for the truth-table sweep.
  logic        w1_in_valid, w1_acc_en, w1_acc_start, w1_out_ready;
  logic [2:0]  w1_op;
  logic        w1_a, w1_b;
  logic        w1_in_ready, w1_out_valid, w1_y;
  logic [15:0] w1_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] m_acc;
  int         m_cnt;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .PIPE(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_en(acc_en), .acc_start(acc_start), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .Y(y), .beat_cnt(beat_cnt)
  );

  logic_gate_unit #(.WIDTH(1), .PIPE(3), .CNT_W(16)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .op(w1_op), .acc_en(w1_acc_en), .acc_start(w1_acc_start), .A(w1_a), .B(w1_b),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .Y(w1_y), .beat_cnt(w1_cnt)
  );

  // Gate truth table
  function automatic logic [7:0] gate(input logic [2:0] f, input logic [7:0] x, input logic [7:0] v);
    case (f)
      3'd0: return x & v;
      3'd1: return x | v;
      3'd2: return ~(x & v);
      3'd3: return ~(x | v);
      3'd4: return x ^ v;
      3'd5: return ~(x ^ v);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // One clock cycle on the main instance. Samples handshakes just before the
  // edge, updates the model on acceptance, returns what was seen.
  task automatic step(output bit acc, output bit xfer, output logic [7:0] yo, output bit ir_ok);
    logic [7:0] r;
    #1;
    acc   = (in_valid && in_ready);
    xfer  = (out_valid && out_ready);
    yo    = y;
    ir_ok = (in_ready === (out_ready | ~out_valid));
    if (acc) begin
      if (!acc_en) begin
        r = gate(op, a, b);
      end else if (acc_start) begin
        r = a;
        m_acc = a;
      end else begin
        r = gate(op, m_acc, a);
        m_acc = r;
      end
      exp_q.push_back(r);
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; acc_en = 1'b0; acc_start = 1'b0; out_ready = 1'b1;
    op = 3'd0; a = 8'h00; b = 8'h00;
    w1_in_valid = 1'b0; w1_acc_en = 1'b0; w1_acc_start = 1'b0; w1_out_ready = 1'b1;
    w1_op = 3'd0; w1_a = 1'b0; w1_b = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    m_acc = 8'h00;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", y); end
    checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (w1_out_valid !== 1'b0 || w1_cnt !== 16'd0) begin errors++; $display("FAIL reset_w1 got ov=%b cnt=%0d exp ov=0 cnt=0", w1_out_valid, w1_cnt); end
    do_reset();
  endtask

  task automatic test_basic;
    bit ac, xf, ok;
    logic [7:0] yo;
    do_reset();
    out_ready = 1'b1; op = 3'd2; a = 8'h0F; b = 8'h3C; in_valid = 1'b1;
    step(ac, xf, yo, ok);
    in_valid = 1'b0;
    checks++; if (!ac) begin errors++; $display("FAIL basic_accept got=0 exp=1"); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    step(ac, xf, yo, ok);
    checks++; if (out_valid !== 1'b1 || y !== 8'hF3) begin errors++; $display("FAIL basic_result got ov=%b y=%h exp ov=1 y=f3", out_valid, y); end
  endtask

  task automatic test_truth_w1;
    logic q[$];
    logic [7:0] t;
    logic exp_b;
    int outs = 0;
    bit gap = 0;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      if (i < 32) begin
        w1_in_valid = 1'b1; w1_op = 3'(i / 4); w1_a = (i % 4) >= 2; w1_b = (i % 2) == 1;
      end else begin
        w1_in_valid = 1'b0;
      end
      #1;
      if (w1_out_valid) begin
        exp_b = (q.size() > 0) ? q.pop_front() : 1'bx;
        checks++; if (w1_y !== exp_b) begin errors++; $display("FAIL w1_truth idx=%0d got=%b exp=%b", outs, w1_y, exp_b); end
        outs++;
      end else if (outs > 0 && outs < 32) begin
        gap = 1;
      end
      if (w1_in_valid && w1_in_ready) begin
        t = gate(w1_op, {7'd0, w1_a}, {7'd0, w1_b});
        q.push_back(t[0]);
      end
      @(posedge clk);
      #1;
    end
    checks++; if (outs != 32 || gap) begin errors++; $display("FAIL w1_throughput got outs=%0d gap=%0d exp outs=32 gap=0", outs, gap); end
    checks++; if (w1_cnt !== 16'd32) begin errors++; $display("FAIL w1_beat_cnt got=%0d exp=32", w1_cnt); end
  endtask

  task automatic test_stall;
    bit ac, xf, ok;
    logic [7:0] yo, hold_y, e;
    logic [7:0] ba[5], bb[5];
    logic [2:0] bo[5];
    int k = 0, got = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin ba[i] = 8'($urandom); bb[i] = 8'($urandom); bo[i] = 3'($urandom); end
    out_ready = 1'b0;
    hold_y = 8'h00;
    for (int c = 0; c < 6; c++) begin
      in_valid = (k < 5); op = bo[k % 5]; a = ba[k % 5]; b = bb[k % 5];
      step(ac, xf, yo, ok);
      if (ac) k++;
      if (c == 2) hold_y = y;
    end
    checks++; if (k != 2) begin errors++; $display("FAIL stall_accepted got=%0d exp=2", k); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got ir=%b ov=%b exp ir=0 ov=1", in_ready, out_valid); end
    checks++; if (y !== hold_y || y !== gate(bo[0], ba[0], bb[0])) begin errors++; $display("FAIL stall_y_stable got=%h exp=%h", y, gate(bo[0], ba[0], bb[0])); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      in_valid = (k < 5); op = bo[k % 5]; a = ba[k % 5]; b = bb[k % 5];
      step(ac, xf, yo, ok);
      if (ac) k++;
      if (xf) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (yo !== e) begin errors++; $display("FAIL stall_order idx=%0d got=%h exp=%h", got, yo, e); end
        got++;
      end
    end
    checks++; if (k != 5 || got != 5) begin errors++; $display("FAIL stall_drain got acc=%0d out=%0d exp 5/5", k, got); end
  endtask

  task automatic test_accum;
    bit ac, xf, ok;
    logic [7:0] yo;
    logic [7:0] av[3] = '{8'h5A, 8'hFF, 8'h0F};
    logic [7:0] ev[3] = '{8'h5A, 8'hA5, 8'hAA};
    int got = 0;
    do_reset();
    out_ready = 1'b1; op = 3'd4; acc_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 3); acc_start = (c == 0); a = av[c % 3]; b = 8'($urandom);
      step(ac, xf, yo, ok);
      if (xf) begin
        checks++; if (got >= 3 || yo !== ev[got % 3]) begin errors++; $display("FAIL accum_xor idx=%0d got=%h exp=%h", got, yo, ev[got % 3]); end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL accum_count got=%0d exp=3", got); end
    // First fold beat after reset without acc_start folds with ACC=0.
    do_reset();
    out_ready = 1'b1; op = 3'd2; acc_en = 1'b1; acc_start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    in_valid = 1'b1;
    step(ac, xf, yo, ok);
    in_valid = 1'b0;
    step(ac, xf, yo, ok);
    checks++; if (out_valid !== 1'b1 || y !== 8'hFF) begin errors++; $display("FAIL accum_zero_start got ov=%b y=%h exp ov=1 y=ff", out_valid, y); end
  endtask

  task automatic test_reset_mid;
    bit ac, xf, ok;
    logic [7:0] yo, e;
    int seen = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      step(ac, xf, yo, ok);
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || y !== 8'h00 || beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_mid got ov=%b y=%h cnt=%0d exp 0/00/0", out_valid, y, beat_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); m_acc = 8'h00; m_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(ac, xf, yo, ok);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_mid_ghost got=%0d exp=0", seen); end
    in_valid = 1'b1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    e = gate(op, a, b);
    step(ac, xf, yo, ok);
    in_valid = 1'b0;
    step(ac, xf, yo, ok);
    checks++; if (out_valid !== 1'b1 || y !== e) begin errors++; $display("FAIL reset_mid_latency got ov=%b y=%h exp ov=1 y=%h", out_valid, y, e); end
  endtask

  task automatic test_cnt_wrap;
    bit ac, xf, ok;
    logic [7:0] yo;
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      in_valid = 1'b1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      step(ac, xf, yo, ok);
      if (ac) n++;
    end
    in_valid = 1'b0;
    checks++; if (n != 17 || beat_cnt !== 4'd1) begin errors++; $display("FAIL cnt_wrap got acc=%0d cnt=%0d exp acc=17 cnt=1", n, beat_cnt); end
  endtask

  task automatic test_random;
    bit ac, xf, ok;
    logic [7:0] yo, e;
    int k = 0, got = 0, bad_ir = 0, cyc = 0;
    do_reset();
    in_valid = 1'b0;
    while ((k < 1000 || got < k) && cyc < 20000) begin
      if (!in_valid || ac) begin
        in_valid  = (k < 1000) && ($urandom_range(1) == 1);
        op        = 3'($urandom);
        acc_en    = ($urandom_range(3) == 0);
        acc_start = ($urandom_range(3) == 0);
        a         = 8'($urandom);
        b         = 8'($urandom);
      end
      out_ready = ($urandom_range(1) == 1);
      step(ac, xf, yo, ok);
      cyc++;
      if (!ok) bad_ir++;
      if (ac) k++;
      if (xf) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (yo !== e) begin errors++; $display("FAIL random_data idx=%0d got=%h exp=%h", got, yo, e); end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++; if (k != 1000 || got != 1000 || exp_q.size() != 0) begin errors++; $display("FAIL random_count got acc=%0d out=%0d left=%0d exp 1000/1000/0", k, got, exp_q.size()); end
    checks++; if (bad_ir != 0) begin errors++; $display("FAIL random_in_ready got=%0d bad cycles exp=0", bad_ir); end
    checks++; if (beat_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL random_beat_cnt got=%0d exp=%0d", beat_cnt, 4'(m_cnt)); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_acc = 8'h00;
    m_cnt = 0;
    test_reset();
    test_basic();
    test_truth_w1();
    test_stall();
    test_accum();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
